// File: rtl/logic_ops_pkg.sv
// Shared definitions for the logic-op issue stage.
//   WIDTH   : default operand/result width
//   OP_*    : 3-bit opcodes understood by LogicalOps
//   req_t   : queued request record {op, chain, a, b}
package logic_ops_pkg;
  localparam int WIDTH = 16;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_TWOS = 3'b111;

  typedef struct packed {
    logic [2:0]       op;
    logic             chain;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;
endpackage

// File: rtl/LogicalOps.sv
// Combinational 16-bit logic unit.
//   a_i, b_i : operands (b_i ignored by NOT and 2s complement)
//   op_i     : opcode from logic_ops_pkg
//   y_o      : result
module LogicalOps
  import logic_ops_pkg::*;
#(
  parameter int WIDTH = logic_ops_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] y_o
);
  always_comb begin
    y_o = '0;
    unique case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_NOT:  y_o = ~a_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NAND: y_o = ~(a_i & b_i);
      OP_NOR:  y_o = ~(a_i | b_i);
      OP_XNOR: y_o = ~(a_i ^ b_i);
      OP_TWOS: y_o = ~a_i + WIDTH'(1);
      default: y_o = '0;
    endcase
  end
endmodule

// File: rtl/logic_req_fifo.sv
// Synchronous request FIFO with asynchronous active-high reset.
//   push_i/din_i : write at tail (ignored when full)
//   pop_i        : drop head (ignored when empty)
//   dout_o       : head entry
//   count_o      : occupancy, 0..DEPTH
module logic_req_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic [CW-1:0] count_o
);
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_push = push_i && (count_q < CW'(DEPTH));
  assign do_pop  = pop_i  && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/logic_op_issue.sv
// Buffered issue/retire stage around LogicalOps.
//   in_*       : request handshake {op, a, b, chain}
//   out_*      : registered result + zero/neg/parity flags, valid/ready
//   count      : queued requests, not counting the result register
// A chained request replaces A with acc, the result of the previously
// issued request, regardless of whether that result has drained.
module logic_op_issue
  import logic_ops_pkg::*;
#(
  parameter int WIDTH = logic_ops_pkg::WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic [2:0]             in_op,
  input  logic                   in_chain,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_result,
  output logic                   out_zero,
  output logic                   out_neg,
  output logic                   out_parity,
  output logic [$clog2(DEPTH):0] count
);
  localparam int CW = $clog2(DEPTH) + 1;

  req_t             push_req, head;
  logic [CW-1:0]    cnt;
  logic             push, issue;
  logic [WIDTH-1:0] op_a, res;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q, acc_q;
  logic             zero_q, neg_q, parity_q;

  assign push_req = '{op: in_op, chain: in_chain, a: in_a, b: in_b};
  assign in_ready = (cnt < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  // Only entries already in the FIFO can issue, so a push into an
  // empty queue waits a cycle.
  assign issue    = (cnt != '0) && (!out_valid_q || out_ready);

  logic_req_fifo #(.DW($bits(req_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (push_req),
    .pop_i   (issue),
    .dout_o  (head),
    .count_o (cnt)
  );

  assign op_a = head.chain ? acc_q : head.a;

  LogicalOps #(.WIDTH(WIDTH)) u_ops (
    .a_i  (op_a),
    .b_i  (head.b),
    .op_i (head.op),
    .y_o  (res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      neg_q       <= 1'b0;
      parity_q    <= 1'b0;
      acc_q       <= '0;
    end else if (issue) begin
      out_valid_q <= 1'b1;
      result_q    <= res;
      zero_q      <= (res == '0);
      neg_q       <= res[WIDTH-1];
      parity_q    <= ^res;
      acc_q       <= res;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_zero   = zero_q;
  assign out_neg    = neg_q;
  assign out_parity = parity_q;
  assign count      = cnt;
endmodule

// File: tb/tb_logic_op_issue.sv
module tb_logic_op_issue;
  localparam int W = 16;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_chain, out_valid, out_ready;
  logic [W-1:0] in_a, in_b, out_result;
  logic [2:0]   in_op;
  logic         out_zero, out_neg, out_parity;
  logic [2:0]   count;

  int n_assert = 0;
  int n_fail   = 0;
  logic [W+2:0] sb[$];
  logic [W-1:0] macc;

  always #5 clk = ~clk;

  logic_op_issue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_chain(in_chain),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_neg(out_neg), .out_parity(out_parity),
    .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'b000: return a & b;
      3'b001: return a | b;
      3'b010: return ~a;
      3'b011: return a ^ b;
      3'b100: return ~(a & b);
      3'b101: return ~(a | b);
      3'b110: return ~(a ^ b);
      default: return (~a) + 16'd1;
    endcase
  endfunction

  task automatic model_push(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic ch);
    logic [W-1:0] r;
    r = ref_op(op, ch ? macc : a, b);
    macc = r;
    sb.push_back({r, (r == '0), r[W-1], ^r});
  endtask

  // One clock: sample both handshakes before the edge, score after it.
  task automatic tick();
    logic fire, acc;
    logic [W+2:0] got, exp;
    #1;
    fire = out_valid && out_ready;
    acc  = in_valid && in_ready;
    got  = {out_result, out_zero, out_neg, out_parity};
    if (acc) model_push(in_op, in_a, in_b, in_chain);
    @(posedge clk); #1;
    if (fire) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        exp = sb.pop_front();
        chk("sb_result", 32'(got), 32'(exp));
      end
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic ch);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_chain = ch;
    tick();
  endtask

  task automatic drain(input int max_cyc);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < max_cyc && (sb.size() != 0 || out_valid); i++) tick();
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("drain_ov", 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    in_chain = 1'b0; out_ready = 1'b1; macc = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(out_result), 32'd0);
    chk("rst_flags", 32'({out_zero, out_neg, out_parity}), 32'b100);
    chk("rst_count", 32'(count), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Single OR: latency of one edge after acceptance.
    send(3'b001, 16'hFFFF, 16'h2495, 1'b0);
    in_valid = 1'b0;
    chk("lat_ov_low", 32'(out_valid), 32'd0);
    chk("lat_count", 32'(count), 32'd1);
    tick();
    chk("or_ov", 32'(out_valid), 32'd1);
    chk("or_result", 32'(out_result), 32'h0000FFFF);
    chk("or_flags", 32'({out_zero, out_neg, out_parity}), 32'b010);
    drain(10);

    // Back-to-back XOR / TWOS / NOT.
    send(3'b011, 16'h1234, 16'h1234, 1'b0);
    send(3'b111, 16'h0001, 16'h5555, 1'b0);
    chk("b2b_xor", 32'(out_result), 32'h0);
    chk("b2b_xor_zero", 32'(out_zero), 32'd1);
    send(3'b010, 16'h00FF, 16'hAAAA, 1'b0);
    chk("b2b_twos", 32'(out_result), 32'h0000FFFF);
    chk("b2b_twos_neg", 32'(out_neg), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("b2b_not", 32'(out_result), 32'h0000FF00);
    chk("b2b_not_ov", 32'(out_valid), 32'd1);
    drain(10);

    // Chained sequence.
    send(3'b000, 16'hF0F0, 16'hFF00, 1'b0);
    send(3'b001, 16'h1234, 16'h000F, 1'b1);
    send(3'b101, 16'hABCD, 16'h0000, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("chain_nor", 32'(out_result), 32'h00000FF0);
    drain(10);

    // Backpressure: six offers, five accepted.
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) send(3'b000, 16'(16'h1111 * k), 16'hFFFF, 1'b0);
    chk("bp_count", 32'(count), 32'd4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_sb_size", 32'(sb.size()), 32'd5);
    chk("bp_head", 32'(out_result), 32'h00001111);
    in_valid = 1'b0;
    tick();
    chk("bp_hold", 32'(out_result), 32'h00001111);
    chk("bp_hold_ov", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_stream_ov", 32'(out_valid), 32'd1);
      tick();
    end
    chk("bp_done_ov", 32'(out_valid), 32'd0);
    chk("bp_done_sb", 32'(sb.size()), 32'd0);

    // Simultaneous push and pop at count=2.
    out_ready = 1'b0;
    send(3'b011, 16'h0F0F, 16'h00FF, 1'b0);
    send(3'b110, 16'h1357, 16'h2468, 1'b0);
    send(3'b100, 16'hFFFF, 16'h8001, 1'b0);
    chk("pp_pre_count", 32'(count), 32'd2);
    out_ready = 1'b1;
    send(3'b001, 16'h0100, 16'h0010, 1'b1);
    chk("pp_count", 32'(count), 32'd2);
    drain(20);

    // Reset mid-operation.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(3'b011, 16'(16'h0101 * k), 16'hAAAA, 1'b0);
    in_valid = 1'b0;
    chk("mr_count", 32'(count), 32'd3);
    chk("mr_ov", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("mr_rst_ov", 32'(out_valid), 32'd0);
    chk("mr_rst_count", 32'(count), 32'd0);
    chk("mr_rst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    macc = '0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'b001, 16'hFFFF, 16'h0F0F, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("mr_chain_acc0", 32'(out_result), 32'h00000F0F);
    drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
